// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   clk_div_state_e : run-control FSM states
//   CLK_DIV_MIN     : smallest legal division ratio
//   clamp_div()     : forces requested ratios below CLK_DIV_MIN up to CLK_DIV_MIN
package clk_div_pkg;

   localparam int unsigned CLK_DIV_MIN = 2;
   localparam int unsigned ST_W        = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } clk_div_state_e;

   // Ratios 0 and 1 cannot produce a 50% output, so they are raised to the minimum.
   function automatic logic [31:0] clamp_div(input logic [31:0] v);
      return (v < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : v;
   endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_shaper.sv
// Output shaper for the programmable clock divider.
// It receives the counter, ratio and run flag that the top will hold in the NEXT
// cycle, so the posedge phase register lines up with the counter register.
// Ports:
//   clk, rst_n : source clock, async active-low reset
//   cnt_i      : next-cycle counter value
//   div_i      : next-cycle division ratio
//   run_i      : next-cycle run flag (divider not idle)
//   clk_o      : divided clock, p_q | n_q
module clk_div_shaper
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             run_i,
   output logic             clk_o
);

   logic p_q;    // posedge phase: high while cnt < N/2 (rounded down)
   logic odd_q;  // ratio of the current period is odd
   logic n_q;    // p_q delayed half a cycle, only for odd ratios

   // Posedge phase and odd/even select, aligned with the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= 1'b0;
         odd_q <= 1'b0;
      end else begin
         p_q   <= run_i && (cnt_i < (div_i >> 1));
         odd_q <= div_i[0];
      end
   end

   // Negedge copy stretches the high phase by half a cycle for odd ratios.
   // Gating with odd_q here keeps the output itself a bare OR.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q & odd_q;
      end
   end

   assign clk_o = p_q | n_q;

endmodule : clk_div_shaper

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes are captured into a pending register and applied only at a period
// boundary (counter wrap), or on the next edge while idle. Dropping en lets the
// current period finish before the output stops, so no runt pulses are produced.
// Optional feature macro: CLK_DIV_TICK_EN adds the 'tick' output (one pulse at the
// first cycle of each output period).
// Ports:
//   clk, rst_n : source clock, async active-low reset
//   en         : run request
//   div_i      : requested ratio (0/1 clamp to 2)
//   div_ld     : 1-cycle strobe capturing div_i as the pending ratio
//   clk_out    : divided clock (OR of two flops inside the shaper)
//   running    : divider in RUN or STOP_PEND
//   ld_pend    : a captured ratio is waiting for the boundary
//   tick       : [CLK_DIV_TICK_EN] first cycle of each period
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_i,
   input  logic             div_ld,
   output logic             clk_out,
   output logic             running,
   output logic             ld_pend
`ifdef CLK_DIV_TICK_EN
   ,
   output logic             tick
`endif
);

   clk_div_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             ld_pend_q, ld_pend_d;
   logic             running_q, running_d;
   logic             last_c;
   logic             apply_c;

   // Next-state: FSM, counter and ratio load.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      ld_pend_d  = ld_pend_q;

      last_c  = (cnt_q == (cur_div_q - CNT_W'(1)));
      // Every idle edge counts as a boundary so idle loads take effect at once.
      apply_c = (state_q == IDLE) || last_c;

      if (apply_c && ld_pend_q) begin
         cur_div_d = pend_div_q;
         ld_pend_d = 1'b0;
      end
      // A load on the boundary edge itself stays pending for the following boundary.
      if (div_ld) begin
         pend_div_d = CNT_W'(clamp_div(32'(div_i)));
         ld_pend_d  = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
            if (!en) begin
               state_d = last_c ? IDLE : STOP_PEND;
            end
         end
         STOP_PEND: begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
            if (en) begin
               state_d = RUN;
            end else if (last_c) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      running_d = (state_d != IDLE);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_div_q  <= CNT_W'(DEF_DIV);
         pend_div_q <= CNT_W'(DEF_DIV);
         ld_pend_q  <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         ld_pend_q  <= ld_pend_d;
         running_q  <= running_d;
      end
   end

   // Shaper sees next-cycle values so its registers align with cnt_q.
   clk_div_shaper #(
      .CNT_W (CNT_W)
   ) u_shaper (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt_i (cnt_d),
      .div_i (cur_div_d),
      .run_i (running_d),
      .clk_o (clk_out)
   );

   assign running = running_q;
   assign ld_pend = ld_pend_q;

`ifdef CLK_DIV_TICK_EN
   logic tick_q, tick_d;

   // Period-start strobe, aligned with cnt_q == 0 while running.
   always_comb begin
      tick_d = running_d && (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;
`endif

endmodule : clk_div_prog
